// File: rtl/jericalla_pkg.sv
// Shared opcodes and instruction-field helpers for the jericalla pipeline.
// Instruction layout (MSB to LSB): op[3:0], rd, rs1, rs2.
package jericalla_pkg;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_SLT = 4'b0100;
    localparam logic [3:0] OP_LW  = 4'b0101;
    localparam logic [3:0] OP_SW  = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;

    // Helpers take a zero-extended instruction so they work for any REG_AW.
    localparam int MAX_INSTR_W = 64;
    localparam int MAX_REG_AW  = 16;

    function automatic logic [MAX_INSTR_W-1:0] field_mask(input int reg_aw);
        return (64'd1 << reg_aw) - 64'd1;
    endfunction

    function automatic logic [3:0] instr_op(input logic [MAX_INSTR_W-1:0] instr, input int reg_aw);
        return 4'(instr >> (3 * reg_aw));
    endfunction

    function automatic logic [MAX_REG_AW-1:0] instr_rd(input logic [MAX_INSTR_W-1:0] instr, input int reg_aw);
        return MAX_REG_AW'((instr >> (2 * reg_aw)) & field_mask(reg_aw));
    endfunction

    function automatic logic [MAX_REG_AW-1:0] instr_rs1(input logic [MAX_INSTR_W-1:0] instr, input int reg_aw);
        return MAX_REG_AW'((instr >> reg_aw) & field_mask(reg_aw));
    endfunction

    function automatic logic [MAX_REG_AW-1:0] instr_rs2(input logic [MAX_INSTR_W-1:0] instr, input int reg_aw);
        return MAX_REG_AW'(instr & field_mask(reg_aw));
    endfunction

    function automatic logic op_is_alu(input logic [3:0] op);
        return op inside {OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_AND};
    endfunction

    function automatic logic op_writes_rd(input logic [3:0] op);
        return op_is_alu(op) || (op == OP_LW);
    endfunction

    function automatic logic op_uses_rs1(input logic [3:0] op);
        return op_is_alu(op) || (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic op_uses_rs2(input logic [3:0] op);
        return op_is_alu(op) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/jericalla_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port.
// The array is named mem so it can be preloaded from outside; it has no reset.
module jericalla_regfile
    import jericalla_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] mem [2**REG_AW];

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/jericalla_pipeline.sv
// Three-stage (A decode/read, B execute/RAM, C write-back) jericalla datapath.
// Define JERICALLA_FWD_EN to build the B->A / C->A bypass; otherwise RAW hazards interlock.
module jericalla_pipeline
    import jericalla_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int REG_AW  = 5,
    parameter  int MEM_AW  = 5,
    localparam int INSTR_W = 4 + 3 * REG_AW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instruction,
    output logic               instr_ready,
    output logic [DATA_W-1:0]  data_out,
    output logic               zf,
    output logic               wb_valid
);

    // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready;
    // the source may hold instr_valid and instruction stable across not-ready cycles.

    logic               a_valid;
    logic [INSTR_W-1:0] a_instr;
    logic [MAX_INSTR_W-1:0] a_ext;
    logic [3:0]         a_op;
    logic [REG_AW-1:0]  a_rd, a_rs1, a_rs2;
    logic [DATA_W-1:0]  rf_rd1, rf_rd2, a_opa, a_opb;

    logic               b_valid, b_we;
    logic [3:0]         b_op;
    logic [REG_AW-1:0]  b_rd;
    logic [DATA_W-1:0]  b_opa, b_opb, b_alu, ram_rdata;
    logic [MEM_AW-1:0]  b_addr;

    logic               c_we;
    logic [REG_AW-1:0]  c_rd;
    logic [DATA_W-1:0]  c_result;

    logic hz1_b, hz2_b, hz1_c, hz2_c, stall, accept;

    logic [DATA_W-1:0] ram_mem [2**MEM_AW];

    assign a_ext = MAX_INSTR_W'(a_instr);
    assign a_op  = instr_op(a_ext, REG_AW);
    assign a_rd  = REG_AW'(instr_rd(a_ext, REG_AW));
    assign a_rs1 = REG_AW'(instr_rs1(a_ext, REG_AW));
    assign a_rs2 = REG_AW'(instr_rs2(a_ext, REG_AW));

    jericalla_regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_regfile (
        .clk    (clk),
        .we     (c_we),
        .waddr  (c_rd),
        .wdata  (c_result),
        .raddr1 (a_rs1),
        .raddr2 (a_rs2),
        .rdata1 (rf_rd1),
        .rdata2 (rf_rd2)
    );

    // b_we/c_we are only set for valid writing ops, so they also carry stage validity.
    assign hz1_b = a_valid && op_uses_rs1(a_op) && b_we && (b_rd == a_rs1);
    assign hz2_b = a_valid && op_uses_rs2(a_op) && b_we && (b_rd == a_rs2);
    assign hz1_c = a_valid && op_uses_rs1(a_op) && c_we && (c_rd == a_rs1);
    assign hz2_c = a_valid && op_uses_rs2(a_op) && c_we && (c_rd == a_rs2);

`ifdef JERICALLA_FWD_EN
    // Only a load in B cannot be bypassed: its data appears at the B->C edge.
    assign stall = (hz1_b || hz2_b) && (b_op == OP_LW);
    assign a_opa = hz1_b ? b_alu : (hz1_c ? c_result : rf_rd1);
    assign a_opb = hz2_b ? b_alu : (hz2_c ? c_result : rf_rd2);
`else
    assign stall = hz1_b || hz2_b || hz1_c || hz2_c;
    assign a_opa = rf_rd1;
    assign a_opb = rf_rd2;
`endif

    assign instr_ready = !stall;
    assign accept      = instr_valid && instr_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_valid <= 1'b0;
            a_instr <= '0;
        end else if (!stall) begin
            a_valid <= accept;
            if (accept) begin
                a_instr <= instruction;
            end
        end
    end

    // A stall leaves A untouched and pushes a bubble into B.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b_valid <= 1'b0;
            b_we    <= 1'b0;
            b_op    <= OP_NOP;
            b_rd    <= '0;
            b_opa   <= '0;
            b_opb   <= '0;
        end else begin
            b_valid <= a_valid && !stall;
            b_we    <= a_valid && !stall && op_writes_rd(a_op);
            b_op    <= a_op;
            b_rd    <= a_rd;
            b_opa   <= a_opa;
            b_opb   <= a_opb;
        end
    end

    always_comb begin
        b_alu = '0;
        case (b_op)
            OP_OR:   b_alu = b_opa | b_opb;
            OP_ADD:  b_alu = b_opa + b_opb;
            OP_SUB:  b_alu = b_opa - b_opb;
            OP_SLT:  b_alu = ($signed(b_opa) < $signed(b_opb)) ? DATA_W'(1) : '0;
            OP_AND:  b_alu = b_opa & b_opb;
            default: b_alu = '0;
        endcase
    end

    assign b_addr    = b_opa[MEM_AW-1:0];
    assign ram_rdata = ram_mem[b_addr];

    always_ff @(posedge clk) begin
        if (b_valid && (b_op == OP_SW)) begin
            ram_mem[b_addr] <= b_opb;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_we     <= 1'b0;
            c_rd     <= '0;
            c_result <= '0;
            wb_valid <= 1'b0;
            data_out <= '0;
            zf       <= 1'b0;
        end else begin
            c_we     <= b_we;
            c_rd     <= b_rd;
            wb_valid <= b_valid;
            if (b_valid) begin
                if (op_is_alu(b_op)) begin
                    c_result <= b_alu;
                    data_out <= b_alu;
                    zf       <= (b_alu == '0);
                end else if (b_op == OP_LW) begin
                    c_result <= ram_rdata;
                    data_out <= ram_rdata;
                end else if (b_op == OP_SW) begin
                    c_result <= b_opb;
                    data_out <= b_opb;
                end
            end
        end
    end

endmodule

// File: tb/tb_jericalla_pipeline.sv
// Directed self-checking bench for jericalla_pipeline (default parameters).
// Retirements are matched in order against a queue of hand-computed {data_out, zf} values.
module tb_jericalla_pipeline;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int MEM_AW  = 5;
    localparam int INSTR_W = 4 + 3 * REG_AW;
    localparam int W       = DATA_W + 1;

`ifdef JERICALLA_FWD_EN
    localparam int EXP_RAW_STALL  = 0;
    localparam int EXP_LOAD_STALL = 1;
`else
    localparam int EXP_RAW_STALL  = 2;
    localparam int EXP_LOAD_STALL = 2;
`endif

    localparam logic [3:0] NOP = 4'd0, OR_ = 4'd1, ADD = 4'd2, SUB = 4'd3;
    localparam logic [3:0] SLT = 4'd4, LW = 4'd5, SW = 4'd6;

    // clock / reset
    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               instr_valid = 1'b0;
    logic [INSTR_W-1:0] instruction = '0;
    logic               instr_ready;
    logic [DATA_W-1:0]  data_out;
    logic               zf;
    logic               wb_valid;

    always #5 clk = ~clk;

    jericalla_pipeline #(.DATA_W(DATA_W), .REG_AW(REG_AW), .MEM_AW(MEM_AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .instr_ready (instr_ready),
        .data_out    (data_out),
        .zf          (zf),
        .wb_valid    (wb_valid)
    );

    int checks   = 0;
    int failures = 0;
    int retired  = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [INSTR_W-1:0] mk(input logic [3:0] op, input logic [4:0] rd,
                                               input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, rs2};
    endfunction

    // scoreboard
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (reset && wb_valid) begin
            retired++;
            if (exp_q.size() == 0) begin
                check("retire_has_expectation", W'(exp_q.size()), W'(1));
            end else begin
                e = exp_q.pop_front();
                check("retire_data_out", W'(data_out), W'(e[W-1:1]));
                check("retire_zf", W'(zf), W'(e[0]));
            end
        end
    end

    // driver tasks: called at a negedge, return at the negedge after acceptance
    task automatic send(input logic [INSTR_W-1:0] ins, input logic [DATA_W-1:0] d,
                        input logic z, input logic expect_retire);
        int guard = 0;
        instr_valid = 1'b1;
        instruction = ins;
        while (!instr_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("accept_within_bound", W'(instr_ready), W'(1));
        if (expect_retire) exp_q.push_back({d, z});
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_not_ready(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            if (!instr_ready) cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int r0;
        for (int i = 0; i < 2**REG_AW; i++) dut.u_regfile.mem[i] = '0;
        for (int i = 0; i < 2**MEM_AW; i++) dut.ram_mem[i] = '0;
        dut.u_regfile.mem[0]  = 32'd222;
        dut.u_regfile.mem[1]  = 32'd111;
        dut.u_regfile.mem[2]  = 32'd100;
        dut.u_regfile.mem[3]  = 32'd200;
        dut.u_regfile.mem[7]  = 32'd20;
        dut.u_regfile.mem[11] = 32'd55;
        dut.u_regfile.mem[12] = 32'd66;

        idle(2);
        check("reset_instr_ready", W'(instr_ready), W'(1));
        check("reset_data_out", W'(data_out), W'(0));
        check("reset_zf", W'(zf), W'(0));
        check("reset_wb_valid", W'(wb_valid), W'(0));
        reset = 1'b1;
        idle(1);

        // single ADD: 222 + 111, retires two edges after acceptance
        send(mk(ADD, 5'd4, 5'd0, 5'd1), 32'd333, 1'b0, 1'b1);
        check("add_wb_n0", W'(wb_valid), W'(0));
        idle(1);
        check("add_wb_n1", W'(wb_valid), W'(0));
        check("add_ready_n1", W'(instr_ready), W'(1));
        idle(1);
        check("add_wb_n2", W'(wb_valid), W'(1));
        check("add_data_n2", W'(data_out), W'(333));
        check("add_zf_n2", W'(zf), W'(0));
        idle(4);

        // distance-1 RAW: SUB r5 = r4 - r1
        send(mk(ADD, 5'd4, 5'd0, 5'd1), 32'd333, 1'b0, 1'b1);
        send(mk(SUB, 5'd5, 5'd4, 5'd1), 32'd222, 1'b0, 1'b1);
        count_not_ready(4, cnt);
        check("raw_stall_cycles", W'(cnt), W'(EXP_RAW_STALL));
        idle(4);

        // SLT, zero result, NOP keeps data_out and zf
        send(mk(SLT, 5'd6, 5'd2, 5'd3), 32'd1, 1'b0, 1'b1);
        send(mk(SUB, 5'd8, 5'd1, 5'd1), 32'd0, 1'b1, 1'b1);
        send(mk(NOP, 5'd0, 5'd0, 5'd0), 32'd0, 1'b1, 1'b1);
        idle(5);

        // store, load, load-use
        send(mk(SW, 5'd0, 5'd7, 5'd4), 32'd333, 1'b1, 1'b1);
        send(mk(LW, 5'd9, 5'd7, 5'd0), 32'd333, 1'b1, 1'b1);
        send(mk(ADD, 5'd10, 5'd9, 5'd9), 32'd666, 1'b0, 1'b1);
        count_not_ready(4, cnt);
        check("load_use_stall_cycles", W'(cnt), W'(EXP_LOAD_STALL));
        idle(5);
        check("ram20_after_sw", W'(dut.ram_mem[20]), W'(333));
        check("rf10_after_add", W'(dut.u_regfile.mem[10]), W'(666));

        // instr_valid held high across stalls: each retires once, in order
        r0 = retired;
        send(mk(LW, 5'd13, 5'd7, 5'd0), 32'd333, 1'b0, 1'b1);
        send(mk(ADD, 5'd14, 5'd13, 5'd1), 32'd444, 1'b0, 1'b1);
        send(mk(OR_, 5'd15, 5'd14, 5'd2), 32'd508, 1'b0, 1'b1);
        idle(8);
        check("held_valid_retire_count", W'(retired - r0), W'(3));
        check("held_valid_queue_drained", W'(exp_q.size()), W'(0));

        // reset with three in flight; only the oldest has reached C (and retired)
        send(mk(ADD, 5'd11, 5'd1, 5'd2), 32'd211, 1'b0, 1'b1);
        send(mk(SW, 5'd0, 5'd7, 5'd3), 32'd0, 1'b0, 1'b0);
        send(mk(ADD, 5'd12, 5'd1, 5'd1), 32'd0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("midrst_instr_ready", W'(instr_ready), W'(1));
        check("midrst_data_out", W'(data_out), W'(0));
        check("midrst_zf", W'(zf), W'(0));
        check("midrst_wb_valid", W'(wb_valid), W'(0));
        idle(2);
        reset = 1'b1;
        idle(3);
        check("midrst_rf11_kept", W'(dut.u_regfile.mem[11]), W'(55));
        check("midrst_rf12_kept", W'(dut.u_regfile.mem[12]), W'(66));
        check("midrst_ram20_kept", W'(dut.ram_mem[20]), W'(333));
        check("final_queue_empty", W'(exp_q.size()), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jericalla_pipeline.md
# jericalla_pipeline

Parametrised three-stage pipelined successor of the single-cycle jericalla datapath. It accepts one register-register instruction per cycle through a valid/ready handshake, executes ALU and RAM operations, and writes results back to its register file. Generalisations over the previous generation:
- configurable data width, register count and RAM depth;
- a load instruction;
- RAW hazard handling, either by forwarding or by interlock.

It sits between the instruction source (bench or a future fetch unit) and the result/flag consumers.

## Interface
Parameters:
- DATA_W, 32, datapath, register and RAM word width
- REG_AW, 5, register-address field width; register file has 2**REG_AW entries
- MEM_AW, 5, RAM address width; RAM has 2**MEM_AW words
- INSTR_W, 4+3*REG_AW (19), instruction width; derived, not overridable

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction present on `instruction`
- instruction  in  INSTR_W  fields: [INSTR_W-1 -: 4] op, then rd, rs1, rs2 (REG_AW bits each, MSB to LSB)
- instr_ready  out  1  block accepts the instruction this cycle
- data_out  out  DATA_W  result of the most recently retired instruction
- zf  out  1  zero flag of the last retired ALU op
- wb_valid  out  1  one-cycle pulse when an instruction retires

## Operation
- Opcodes:
  - 0000 NOP
  - 0001 OR
  - 0010 ADD
  - 0011 SUB (rs1-rs2)
  - 0100 SLT (signed; result 1/0)
  - 0101 LW: RF[rd] = RAM[RF[rs1][MEM_AW-1:0]]
  - 0110 SW: RAM[RF[rs1][MEM_AW-1:0]] = RF[rs2]; rd ignored
  - 0111 AND
  - 1000-1111 execute as NOP
- ALU ops write RF[rd] = result.
- Arithmetic is modulo 2**DATA_W; carry and overflow are discarded.
- Register 0 is an ordinary writable register.
- Stages:
  - A: decode and RF read.
  - B: ALU, plus synchronous RAM read/write at the B→C edge.
  - C: write-back; the RF write occurs at the edge leaving C.
- A NOP or invalid-opcode instruction still occupies a slot, retires with wb_valid=1 and does not change data_out or zf.
- data_out on retire:
  - ALU op: result
  - LW: loaded word
  - SW: the stored value
- zf = (result == 0) for ALU ops only. zf holds its previous value for LW, SW and NOP.
- Hazards: a source register of the instruction in A that matches a valid, writing destination in B or C is a RAW hazard.
  - B takes priority over C when both match.
  - With forwarding, a hazard against an LW in B stalls one cycle.
- Stall behaviour:
  - instr_ready=0; A holds its instruction; a bubble is inserted into B.
  - The source may hold instr_valid; the instruction is accepted only when instr_valid && instr_ready.

## Timing
- Instruction accepted at edge n.
- Operands registered into B at edge n+1.
- data_out, zf and wb_valid updated at edge n+2.
- RF written at edge n+3; a same-cycle read of that register is covered by the C-stage bypass or interlock.
- Throughput is one instruction per cycle when there is no stall.
- Reset:
  - Asserting reset mid-operation clears every stage valid; in-flight instructions are lost and their RF/RAM writes are not performed.
  - Reset values: instr_ready=1, data_out=0, zf=0, wb_valid=0.
  - RF and RAM are not reset; they are preloaded externally.
- Simultaneous SW in C and LW in B to the same address: the RAM is write-first, so the LW returns the new value.

## Configuration
- JERICALLA_FWD_EN defined:
  - B→A and C→A bypass muxes are built.
  - Stalls occur only for load-use (LW in B).
- JERICALLA_FWD_EN undefined:
  - No bypass is built.
  - Any RAW hazard against B or C stalls until the producer has written the RF.
  - A dependency at distance 1 therefore costs 2 stall cycles.

## Structure
- Shared package jericalla_pkg: opcode localparams and the instruction field extract helpers for op/rd/rs1/rs2.
- Sub-module jericalla_regfile: 2 async read ports, 1 sync write port. Its array is named `mem` so benches can preload it with $readmemb.
- RAM is an inline array `ram_mem` in the top module.

## Test plan
Common preload: RF[0]=222, RF[1]=111, RF[2]=100, RF[3]=200, RF[7]=20.
- ADD rd4, rs0, rs1, accepted after reset release -> 2 cycles later wb_valid=1, data_out=333, zf=0, instr_ready stays 1.
- ADD r4 then immediately SUB rd5, rs4, rs1:
  - with JERICALLA_FWD_EN: data_out=222 one cycle after 333, no stall;
  - without: 2 cycles with instr_ready=0, then data_out=222.
- SLT rd6, rs2, rs3 -> data_out=1, zf=0; then SUB rd8, rs1, rs1 -> data_out=0, zf=1; then NOP -> zf still 1.
- SW rs1=7, rs2=4 (RAM[20]=333), then LW rd9, rs7, then ADD rd10, rs9, rs9:
  - LW retires with data_out=333;
  - a load-use stall of 1 cycle occurs with forwarding;
  - ADD result is 666.
- Hold instr_valid high for 3 instructions while a stall occurs -> each instruction retires exactly once, in order.
- Assert reset while 3 instructions are in flight -> outputs go to reset values immediately; none of the three writes reaches RF or RAM.
